// File: rtl/pulse_stretch_out.sv
// -----------------------------------------------------------------------------
// pulse_stretch_out
//
// Purpose:
//   Output-side pulse stretcher for human-visible outputs (LEDs, buzzer, relay
//   strobes). It turns each 1-cycle internal event into an active phase of
//   exactly HOLD clk cycles. The active phase is followed by a forced inactive
//   phase of GAP cycles, so back-to-back events remain distinguishable. There is
//   one independent channel per bus bit.
//
// Parameters:
//   WIDTH      number of channels
//   POLARITY   "HIGH": active output level 1, "LOW": active output level 0
//   HOLD       active phase length in cycles (1..2**CNT_WIDTH-1)
//   GAP        inactive phase length in cycles (1..2**CNT_WIDTH-1)
//   CNT_WIDTH  per-channel counter width
//
// Ports:
//   clk       in   1      clock, all logic on posedge
//   reset     in   1      asynchronous, active-high reset
//   data_in   in   WIDTH  event requests; an event is a sampled 0->1 edge
//   data_out  out  WIDTH  stretched outputs at POLARITY level, registered
//   busy      out  WIDTH  1 while a channel is in ON or GAP, registered
//
// Build option:
//   PULSE_STRETCH_RETRIGGER_EN  when defined, an event during ON restarts the
//                               hold. When undefined, the event is queued as
//                               pending (one deep).
// -----------------------------------------------------------------------------
module pulse_stretch_out #(
    parameter int unsigned WIDTH     = 3,
    parameter string       POLARITY  = "LOW",
    parameter int unsigned HOLD      = 50000,
    parameter int unsigned GAP       = 12500,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] busy
);

    localparam logic ACT_LVL = (POLARITY == "LOW") ? 1'b0 : 1'b1;
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Previous data_in sample, shared by all channels for edge detection.
    // It is cleared by reset, so an input that is already high at release
    // is seen as an event.
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= data_in;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t               state_q;
        state_t               state_d;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;
        logic                 pend_q;
        logic                 pend_d;
        logic                 evt;
        logic                 out_q;
        logic                 busy_q;

        assign evt = data_in[i] & ~prev_q[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pend_d  = pend_q;
            case (state_q)
                S_IDLE: begin
                    if (evt) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                    end
                end
                S_ON: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                    // A new event restarts the hold even on its last cycle.
                    if (evt) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    // An event while pending is already set is dropped.
                    if (evt) begin
                        pend_d = 1'b1;
                    end
                    if (cnt_q == HOLD_LAST) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (pend_q || evt) begin
                            state_d = S_ON;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (evt) begin
                            pend_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            endcase
        end

        // The outputs are registered from the current state. As a result,
        // data_out and busy lag the state by one edge, which gives a latency
        // of one cycle from the sampling edge.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
                out_q   <= ~ACT_LVL;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
                out_q   <= (state_q == S_ON) ? ACT_LVL : ~ACT_LVL;
                busy_q  <= (state_q != S_IDLE);
            end
        end

        assign data_out[i] = out_q;
        assign busy[i]     = busy_q;
    end

endmodule

// File: tb/tb_pulse_stretch_out.sv
module tb_pulse_stretch_out;

    localparam int HOLD = 4;
    localparam int GAP  = 2;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] data_in;
    logic [1:0] dout_h;
    logic [1:0] busy_h;
    logic [1:0] dout_l;
    logic [1:0] busy_l;

    int checks = 0;
    int errors = 0;

    // The reference model is a per-channel phase start edge plus a pending
    // flag. The state is derived from interval arithmetic on edge numbers.
    int         n;
    int         s_m [2];
    bit         pend_m [2];
    logic [1:0] prev_m;

    pulse_stretch_out #(.WIDTH(2), .POLARITY("HIGH"), .HOLD(HOLD), .GAP(GAP), .CNT_WIDTH(3)) u_dut_h (
        .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout_h), .busy(busy_h));

    pulse_stretch_out #(.WIDTH(2), .POLARITY("LOW"), .HOLD(HOLD), .GAP(GAP), .CNT_WIDTH(3)) u_dut_l (
        .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout_l), .busy(busy_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        prev_m = '0;
        for (int c = 0; c < 2; c++) begin
            s_m[c]    = -100000;
            pend_m[c] = 1'b0;
        end
    endtask

    // The task is entered at a negedge. It drives din, which is sampled at
    // the next posedge. It then checks the outputs #1 later and returns at
    // the following negedge.
    task automatic step(input logic [1:0] din);
        logic [1:0] exp_out;
        logic [1:0] exp_busy;
        int         t;
        bit         on_ph;
        bit         gap_ph;
        bit         ev;
        data_in = din;
        @(posedge clk);
        n++;
        for (int c = 0; c < 2; c++) begin
            t        = n - 1 - s_m[c];
            on_ph    = (t >= 0) && (t < HOLD);
            gap_ph   = (t >= HOLD) && (t < HOLD + GAP);
            exp_out[c]  = on_ph;
            exp_busy[c] = on_ph | gap_ph;
            ev = din[c] & ~prev_m[c];
            if (!on_ph && !gap_ph) begin
                if (ev) s_m[c] = n;
            end else if (on_ph) begin
                if (ev) begin
                    if (RETRIG) s_m[c] = n;
                    else pend_m[c] = 1'b1;
                end
            end else begin
                if (t == HOLD + GAP - 1) begin
                    if (pend_m[c] || ev) begin
                        s_m[c]    = n;
                        pend_m[c] = 1'b0;
                    end
                end else if (ev) begin
                    pend_m[c] = 1'b1;
                end
            end
        end
        prev_m = din;
        #1;
        check("out_high", {14'd0, dout_h}, {14'd0, exp_out});
        check("busy_high", {14'd0, busy_h}, {14'd0, exp_busy});
        check("out_low", {14'd0, dout_l}, {14'd0, ~exp_out});
        check("busy_low", {14'd0, busy_l}, {14'd0, exp_busy});
        @(negedge clk);
    endtask

    // Reset is asserted asynchronously in the middle of a cycle, and the
    // outputs are checked immediately.
    task automatic apply_reset(input int cycles);
        #2;
        reset = 1'b1;
        #1;
        check("rst_out_high", {14'd0, dout_h}, 16'h0000);
        check("rst_out_low", {14'd0, dout_l}, 16'h0003);
        check("rst_busy", {12'd0, busy_h, busy_l}, 16'h0000);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step(2'b00);
    endtask

    initial begin
        logic [15:0] rec_o;
        logic [15:0] rec_b;
        int          rises;
        logic [1:0]  din;

        reset   = 1'b1;
        data_in = 2'b00;
        n       = 0;
        model_reset();
        #1;
        check("por_out_high", {14'd0, dout_h}, 16'h0000);
        check("por_out_low", {14'd0, dout_l}, 16'h0003);
        check("por_busy", {12'd0, busy_h, busy_l}, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Test 1: single pulse. Record the outputs at edges k..k+7.
        rec_o = '0;
        rec_b = '0;
        for (int i = 0; i < 8; i++) begin
            step(i == 0 ? 2'b01 : 2'b00);
            rec_o[i] = dout_h[0];
            rec_b[i] = busy_h[0];
            if (dout_h[1] !== 1'b0) rec_o[15] = 1'b1;
        end
        check("t1_out_timing", rec_o, 16'h001E);
        check("t1_busy_timing", rec_b, 16'h007E);
        idle(3);

        // Test 2/3: pulses at k and k+2.
        rec_o = '0;
        for (int i = 0; i < 14; i++) begin
            step((i == 0 || i == 2) ? 2'b01 : 2'b00);
            rec_o[i] = dout_h[0];
        end
`ifdef PULSE_STRETCH_RETRIGGER_EN
        check("t3_out_timing", rec_o, 16'h007E);
`else
        check("t2_out_timing", rec_o, 16'h079E);
`endif
        idle(3);

        // Test 4: three pulses during one ON phase.
        rises = 0;
        rec_o = '0;
        for (int i = 0; i < 16; i++) begin
            step((i == 0 || i == 2 || i == 4) ? 2'b01 : 2'b00);
            rec_o[i] = dout_h[0];
            if (i > 0 && rec_o[i] && !rec_o[i-1]) rises++;
        end
        check("t4_phase_count", 16'(rises), RETRIG ? 16'd1 : 16'd2);
        idle(3);

        // Test 5: reset in the middle of a phase, then quiet after release.
        step(2'b01);
        step(2'b00);
        step(2'b00);
        apply_reset(2);
        idle(10);

        // An input that is already high at reset release counts as an event.
        data_in = 2'b10;
        apply_reset(2);
        step(2'b10);
        idle(10);

        // Test 6: both channels in the same cycle, then on different cycles.
        step(2'b11);
        idle(9);
        step(2'b01);
        step(2'b00);
        step(2'b10);
        idle(10);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) apply_reset($urandom_range(1, 3));
            din[0] = ($urandom_range(0, 2) == 0);
            din[1] = ($urandom_range(0, 3) == 0);
            step(din);
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
